prog_mem_loader: RTL

- Parametrised boot program memory.
- Accepts a byte stream from the external ROM reader and packs it little-endian into WORD_WIDTH-bit words in on-chip block RAM.
- Serves NUM_PORTS independent read ports with fixed latency, and pulses a system reset once the image is loaded.
- Sits between the ROM reader and the CPU fetch and load paths.

---
 rtl/prog_mem_pkg.sv | 18 +
 rtl/prog_mem_loader_if.sv | 25 ++
 rtl/byte_packer.sv | 62 ++++++
 rtl/prog_mem_loader.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types and helpers for the boot program memory loader.
package prog_mem_pkg;

  typedef enum logic [1:0] {
    LOADING = 2'd0,
    FLUSH   = 2'd1,
    RELEASE = 2'd2,
    SERVING = 2'd3
  } prog_mem_state_t;

  localparam int LAT_LOW  = 1;
  localparam int LAT_HIGH = 2;

  function automatic int bytes_per_word(input int word_width);
    return word_width / 8;
  endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// Image byte stream from the ROM reader plus the per-port CPU read bus.
interface prog_mem_loader_if #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32
);
  logic                             rom_valid_in;
  logic [7:0]                       rom_data_in;
  logic                             rom_done_in;
  logic [NUM_PORTS-1:0]             rd_req_in;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]  rd_addr_in;
  logic [NUM_PORTS*WORD_WIDTH-1:0]  rd_data_out;
  logic [NUM_PORTS-1:0]             rd_valid_out;
  logic [NUM_PORTS-1:0]             rd_err_out;

  modport master (
    output rom_valid_in, rom_data_in, rom_done_in, rd_req_in, rd_addr_in,
    input  rd_data_out, rd_valid_out, rd_err_out
  );

  modport slave (
    input  rom_valid_in, rom_data_in, rom_done_in, rd_req_in, rd_addr_in,
    output rd_data_out, rd_valid_out, rd_err_out
  );
endinterface

// File: rtl/byte_packer.sv
// Packs bytes little-endian into words; emits a word on the byte that fills
// the last lane, or a zero-padded partial word when flushed.
module byte_packer
  import prog_mem_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  byte_vld_i,
  input  logic [7:0]            byte_i,
  input  logic                  flush_i,
  output logic                  word_vld_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  partial_o
);
  localparam int BPW    = bytes_per_word(WORD_WIDTH);
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [WORD_WIDTH-1:0] asm_q, asm_d;
  logic [WORD_WIDTH-1:0] lane_mask;

  assign partial_o = (lane_q != '0);

  always_comb begin
    asm_d      = asm_q;
    lane_d     = lane_q;
    word_vld_o = 1'b0;
    word_o     = asm_q;
    lane_mask  = '0;
    // Lanes at or above the fill point may hold bytes of an earlier word.
    for (int l = 0; l < BPW; l++) begin
      if (LANE_W'(l) < lane_q) lane_mask[8*l +: 8] = 8'hFF;
    end
    if (byte_vld_i) begin
      asm_d[8*int'(lane_q) +: 8] = byte_i;
      if (lane_q == LAST_LANE) begin
        word_vld_o = 1'b1;
        word_o     = asm_d;
        lane_d     = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end else if (flush_i) begin
      word_vld_o = 1'b1;
      word_o     = asm_q & lane_mask;
      lane_d     = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lane_q <= '0;
    else          lane_q <= lane_d;
  end

  always_ff @(posedge clk_i) begin
    asm_q <= asm_d;
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Boot program memory: loads a ROM byte image into RAM, pulses a system
// reset when done, then serves fixed-latency reads on each port.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int DEPTH        = 2048,
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  prog_mem_loader_if.slave       bus,
  output logic                   sys_rst_out,
  output logic                   ready_out,
  output logic                   overflow_out,
  output logic [$clog2(DEPTH):0] words_loaded_out
);
  localparam int BPW   = bytes_per_word(WORD_WIDTH);
  localparam int OFF_W = (BPW > 1) ? $clog2(BPW) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  prog_mem_state_t       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_en;
  logic                  pk_vld, pk_partial;
  logic [WORD_WIDTH-1:0] pk_word;
  logic [WORD_WIDTH-1:0] mem [DEPTH];

  byte_packer #(.WORD_WIDTH(WORD_WIDTH)) u_packer (
    .clk_i      (clk_in),
    .rst_n_i    (rst_n_in),
    .byte_vld_i (bus.rom_valid_in && (state_q == LOADING)),
    .byte_i     (bus.rom_data_in),
    .flush_i    ((state_q == FLUSH) && pk_partial),
    .word_vld_o (pk_vld),
    .word_o     (pk_word),
    .partial_o  (pk_partial)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOADING: if (bus.rom_done_in) state_d = FLUSH;
      FLUSH:   state_d = RELEASE;
      RELEASE: state_d = SERVING;
      default: state_d = state_q;
    endcase
  end

  // Words beyond DEPTH are dropped; the count saturates and overflow sticks.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    wr_en = 1'b0;
    if (pk_vld) begin
      if (cnt_q == DEPTH_C) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= LOADING;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[cnt_q[IDX_W-1:0]] <= pk_word;
  end

  assign sys_rst_out      = (state_q == RELEASE);
  assign ready_out        = (state_q == SERVING);
  assign overflow_out     = ovf_q;
  assign words_loaded_out = cnt_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] widx;
    logic                  acc, oor;
    logic                  vld_p1_q, err_p1_q;
    logic [WORD_WIDTH-1:0] data_p1_q;
    logic                  vld_o, err_o;
    logic [WORD_WIDTH-1:0] data_o;

    assign widx = bus.rd_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH] >> OFF_W;
    assign acc  = bus.rd_req_in[p] && (state_q == SERVING);
    assign oor  = (widx >= DEPTH_A);

    // p1: synchronous RAM read
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        vld_p1_q <= 1'b0;
        err_p1_q <= 1'b0;
      end else begin
        vld_p1_q <= acc;
        err_p1_q <= oor;
      end
    end

    always_ff @(posedge clk_in) begin
      if (acc) data_p1_q <= mem[widx[IDX_W-1:0]];
    end

    if (READ_LATENCY == LAT_HIGH) begin : g_oreg
      logic                  vld_p2_q, err_p2_q;
      logic [WORD_WIDTH-1:0] data_p2_q;

      // p2: output register
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          vld_p2_q <= 1'b0;
          err_p2_q <= 1'b0;
        end else begin
          vld_p2_q <= vld_p1_q;
          err_p2_q <= err_p1_q;
        end
      end

      always_ff @(posedge clk_in) begin
        if (vld_p1_q) data_p2_q <= data_p1_q;
      end

      assign vld_o  = vld_p2_q;
      assign err_o  = err_p2_q;
      assign data_o = data_p2_q;
    end else begin : g_noreg
      assign vld_o  = vld_p1_q;
      assign err_o  = err_p1_q;
      assign data_o = data_p1_q;
    end

    assign bus.rd_valid_out[p] = vld_o;
    assign bus.rd_err_out[p]   = vld_o & err_o;
    assign bus.rd_data_out[p*WORD_WIDTH +: WORD_WIDTH] = (vld_o && !err_o) ? data_o : '0;
  end

endmodule
